// File: rtl/wb_biu_mc.sv
// Multi-channel Wishbone bus interface unit: round-robin arbitration between
// line requesters, then a pipelined burst of BEATS single-word Wishbone cycles.
module wb_biu_mc #(
    parameter int OPTN_ADDR_WIDTH    = 32,
    parameter int OPTN_WB_DATA_WIDTH = 16,
    parameter int OPTN_WB_ADDR_WIDTH = 32,
    parameter int OPTN_DC_LINE_SIZE  = 32,
    parameter int OPTN_BIU_NUM_CH    = 2
) (
    input  logic                                              i_wb_clk,
    input  logic                                              i_wb_rst_n,
    input  logic                                              i_wb_ack,
    input  logic                                              i_wb_err,
    input  logic                                              i_wb_stall,
    input  logic [OPTN_WB_DATA_WIDTH-1:0]                     i_wb_data,
    output logic                                              o_wb_cyc,
    output logic                                              o_wb_stb,
    output logic                                              o_wb_we,
    output logic [OPTN_WB_DATA_WIDTH/8-1:0]                   o_wb_sel,
    output logic [OPTN_WB_ADDR_WIDTH-1:0]                     o_wb_addr,
    output logic [OPTN_WB_DATA_WIDTH-1:0]                     o_wb_data,
    input  logic [OPTN_BIU_NUM_CH-1:0]                        i_biu_en,
    input  logic [OPTN_BIU_NUM_CH-1:0]                        i_biu_we,
    input  logic [OPTN_BIU_NUM_CH*OPTN_ADDR_WIDTH-1:0]        i_biu_addr,
    input  logic [OPTN_BIU_NUM_CH*OPTN_DC_LINE_SIZE*8-1:0]    i_biu_data,
    output logic [OPTN_DC_LINE_SIZE*8-1:0]                    o_biu_data,
    output logic [OPTN_BIU_NUM_CH-1:0]                        o_biu_busy,
    output logic [OPTN_BIU_NUM_CH-1:0]                        o_biu_done,
    output logic [OPTN_BIU_NUM_CH-1:0]                        o_biu_err
);

    localparam int WB_WORD_SIZE = OPTN_WB_DATA_WIDTH / 8;
    localparam int LINE_W       = OPTN_DC_LINE_SIZE * 8;
    localparam int BEATS        = LINE_W / OPTN_WB_DATA_WIDTH;
    localparam int OFF_W        = $clog2(OPTN_DC_LINE_SIZE);
    localparam int CNT_W        = $clog2(BEATS + 1);
    localparam int CH_W         = (OPTN_BIU_NUM_CH > 1) ? $clog2(OPTN_BIU_NUM_CH) : 1;
    localparam int EXT_W        = (OPTN_ADDR_WIDTH > OPTN_WB_ADDR_WIDTH) ? OPTN_ADDR_WIDTH
                                                                         : OPTN_WB_ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQS = 2'd1,
        S_ACKS = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [CH_W-1:0]                 rr_q, rr_d;
    logic [CH_W-1:0]                 grant_q, grant_d;
    logic                            we_q, we_d;
    logic [LINE_W-1:0]               line_q, line_d;
    logic [OPTN_WB_ADDR_WIDTH-1:0]   base_q, base_d;
    logic [CNT_W-1:0]                req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]                rsp_cnt_q, rsp_cnt_d;
    logic                            err_q, err_d;
    logic [LINE_W-1:0]               buf_q, buf_d;

    logic                            pick_found_s;
    logic [CH_W-1:0]                 pick_ch_s;
    logic [CH_W:0]                   idx_w_s;
    logic [CH_W-1:0]                 rr_idx_s;
    logic [OPTN_ADDR_WIDTH-1:0]      sel_addr_s;
    logic [OPTN_ADDR_WIDTH-1:0]      addr_clr_s;
    logic [EXT_W-1:0]                addr_ext_s;
    logic                            rsp_valid_s;
    logic                            beat_acc_s;

    // Round-robin pick: first enabled channel at or after rr_q, wrapping.
    always_comb begin
        pick_found_s = 1'b0;
        pick_ch_s    = '0;
        idx_w_s      = '0;
        rr_idx_s     = '0;
        for (int i = 0; i < OPTN_BIU_NUM_CH; i++) begin
            idx_w_s      = {1'b0, rr_q} + (CH_W+1)'(i);
            idx_w_s      = (idx_w_s >= (CH_W+1)'(OPTN_BIU_NUM_CH))
                           ? idx_w_s - (CH_W+1)'(OPTN_BIU_NUM_CH) : idx_w_s;
            rr_idx_s     = idx_w_s[CH_W-1:0];
            pick_ch_s    = (!pick_found_s && i_biu_en[rr_idx_s]) ? rr_idx_s : pick_ch_s;
            pick_found_s = pick_found_s | i_biu_en[rr_idx_s];
        end
    end

    // Line-aligned base address of the picked channel.
    always_comb begin
        sel_addr_s = i_biu_addr[pick_ch_s*OPTN_ADDR_WIDTH +: OPTN_ADDR_WIDTH];
        addr_clr_s = (sel_addr_s >> OFF_W) << OFF_W;
        addr_ext_s = EXT_W'(addr_clr_s);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            state_q   <= S_IDLE;
            rr_q      <= '0;
            grant_q   <= '0;
            we_q      <= 1'b0;
            line_q    <= '0;
            base_q    <= '0;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
            err_q     <= 1'b0;
            buf_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            we_q      <= we_d;
            line_q    <= line_d;
            base_q    <= base_d;
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            err_q     <= err_d;
            buf_q     <= buf_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        we_d      = we_q;
        line_d    = line_q;
        base_d    = base_q;
        req_cnt_d = req_cnt_q;
        rsp_cnt_d = rsp_cnt_q;
        err_d     = err_q;
        buf_d     = buf_q;

        // A response only counts while a beat is actually outstanding.
        rsp_valid_s = ((state_q == S_REQS) || (state_q == S_ACKS)) &&
                      (i_wb_ack || i_wb_err) && (rsp_cnt_q != req_cnt_q);
        beat_acc_s  = (state_q == S_REQS) && !i_wb_stall;

        if (rsp_valid_s) begin
            rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
            if (i_wb_err) begin
                err_d = 1'b1;
            end else if (!we_q) begin
                buf_d[int'(rsp_cnt_q)*OPTN_WB_DATA_WIDTH +: OPTN_WB_DATA_WIDTH] = i_wb_data;
            end else begin
                buf_d = buf_q;
            end
        end else begin
            rsp_cnt_d = rsp_cnt_q;
        end

        if (beat_acc_s) begin
            req_cnt_d = req_cnt_q + CNT_W'(1);
        end else begin
            req_cnt_d = req_cnt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (pick_found_s) begin
                    grant_d   = pick_ch_s;
                    we_d      = i_biu_we[pick_ch_s];
                    line_d    = i_biu_data[pick_ch_s*LINE_W +: LINE_W];
                    base_d    = addr_ext_s[OPTN_WB_ADDR_WIDTH-1:0];
                    req_cnt_d = '0;
                    rsp_cnt_d = '0;
                    err_d     = 1'b0;
                    state_d   = S_REQS;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_REQS: begin
                if ((rsp_valid_s && i_wb_err) ||
                    (beat_acc_s && (req_cnt_q == CNT_W'(BEATS - 1)))) begin
                    state_d = S_ACKS;
                end else begin
                    state_d = S_REQS;
                end
            end
            S_ACKS: begin
                if (rsp_cnt_d == req_cnt_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ACKS;
                end
            end
            S_DONE: begin
                if (!i_biu_en[grant_q]) begin
                    state_d = S_IDLE;
                    rr_d    = (grant_q == CH_W'(OPTN_BIU_NUM_CH - 1)) ? '0
                                                                      : grant_q + CH_W'(1);
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_wb_sel   = '1;
    assign o_biu_data = buf_q;

    // Output decode from the registered state only.
    always_comb begin
        o_wb_cyc   = 1'b0;
        o_wb_stb   = 1'b0;
        o_wb_we    = 1'b0;
        o_wb_addr  = '0;
        o_wb_data  = '0;
        o_biu_busy = '0;
        o_biu_done = '0;
        o_biu_err  = '0;
        case (state_q)
            S_REQS: begin
                o_wb_cyc            = 1'b1;
                o_wb_stb            = 1'b1;
                o_wb_we             = we_q;
                o_wb_addr           = base_q + (OPTN_WB_ADDR_WIDTH'(req_cnt_q) *
                                                OPTN_WB_ADDR_WIDTH'(WB_WORD_SIZE));
                o_wb_data           = line_q[int'(req_cnt_q)*OPTN_WB_DATA_WIDTH +: OPTN_WB_DATA_WIDTH];
                o_biu_busy[grant_q] = 1'b1;
            end
            S_ACKS: begin
                o_wb_cyc            = 1'b1;
                o_wb_we             = we_q;
                o_biu_busy[grant_q] = 1'b1;
            end
            S_DONE: begin
                o_biu_done[grant_q] = 1'b1;
                o_biu_err[grant_q]  = err_q;
            end
            default: begin
                o_wb_cyc = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/wb_biu_mc.md
WB_BIU_MC -- requirements
Module: wb_biu_mc

Interface
REQ-001 SHALL have parameter OPTN_ADDR_WIDTH, default 32, CCU address width.
REQ-002 SHALL have parameter OPTN_WB_DATA_WIDTH, default 16, Wishbone data width (multiple of 8).
REQ-003 SHALL have parameter OPTN_WB_ADDR_WIDTH, default 32, Wishbone address width.
REQ-004 SHALL have parameter OPTN_DC_LINE_SIZE, default 32, line size in bytes (power of 2).
REQ-005 SHALL have parameter OPTN_BIU_NUM_CH, default 2, number of requester channels (N >= 1).
REQ-006 Derived: WB_WORD_SIZE = OPTN_WB_DATA_WIDTH/8; LINE_W = OPTN_DC_LINE_SIZE*8; BEATS = LINE_W/OPTN_WB_DATA_WIDTH.
REQ-007 SHALL use one clock and a synchronous, active-low reset.
REQ-008 i_wb_clk  in  1  clock.
REQ-009 i_wb_rst_n  in  1  synchronous active-low reset.
REQ-010 i_wb_ack / i_wb_err / i_wb_stall  in  1 each  Wishbone pipelined responses and stall.
REQ-011 i_wb_data  in  OPTN_WB_DATA_WIDTH  read data.
REQ-012 o_wb_cyc / o_wb_stb / o_wb_we  out  1 each  Wishbone control.
REQ-013 o_wb_sel  out  WB_WORD_SIZE  byte select, always all ones.
REQ-014 o_wb_addr  out  OPTN_WB_ADDR_WIDTH; o_wb_data  out  OPTN_WB_DATA_WIDTH.
REQ-015 i_biu_en, i_biu_we  in  N  per-channel request and write flag.
REQ-016 i_biu_addr  in  N*OPTN_ADDR_WIDTH; i_biu_data  in  N*LINE_W  packed, channel c at slice c.
REQ-017 o_biu_data  out  LINE_W  shared read-line buffer.
REQ-018 o_biu_busy, o_biu_done, o_biu_err  out  N  per-channel status.

Function
REQ-019 FSM states IDLE, REQS, ACKS, DONE; one transaction at a time.
REQ-020 IDLE: if any i_biu_en, grant first enabled channel at or above round-robin pointer rr (wrapping mod N); latch grant, we, write line and base address; -> REQS next cycle.
REQ-021 Base address = i_biu_addr[grant] with low $clog2(OPTN_DC_LINE_SIZE) bits cleared, truncated/zero-extended to OPTN_WB_ADDR_WIDTH.
REQ-022 REQS: o_wb_cyc=o_wb_stb=1; o_wb_addr = base + req_idx*WB_WORD_SIZE (mod 2^OPTN_WB_ADDR_WIDTH); o_wb_data = latched line slice req_idx; beat accepted when stb & ~i_wb_stall.
REQ-023 Address/data/we SHALL hold stable while i_wb_stall=1.
REQ-024 REQS -> ACKS the cycle after the BEATS-th beat is accepted, or immediately after any i_wb_err.
REQ-025 Responses (ack or err) SHALL be counted in REQS and ACKS; responses with zero outstanding beats ignored.
REQ-026 Read ack at response index k SHALL write i_wb_data into buffer slice k; writes leave buffer unchanged.
REQ-027 i_wb_err SHALL set sticky err flag and stop issuing further beats; o_wb_stb=0 from next cycle.
REQ-028 ACKS: o_wb_cyc=1, o_wb_stb=0; -> DONE when responses == beats issued.
REQ-029 DONE: o_wb_cyc=0; o_biu_done[grant]=1, o_biu_err[grant]=err flag, o_biu_data valid; -> IDLE when i_biu_en[grant]=0; on exit rr = (grant+1) mod N.
REQ-030 o_biu_busy[grant]=1 in REQS/ACKS only; all other channel bits 0.
REQ-031 Changes on i_biu_* inputs after grant SHALL not affect the transaction in flight.
REQ-032 Simultaneous ack and final-beat acceptance in same cycle SHALL both be counted.

Reset
REQ-033 While i_wb_rst_n=0 at a clock edge: state IDLE, rr=0, counters 0, err flag 0, buffer 0; all outputs 0 except o_wb_sel.
REQ-034 Reset mid-transaction SHALL drop o_wb_cyc/o_wb_stb the next cycle with no done/err report.

Verification (defaults, BEATS=16)
REQ-035 Ch0 read 0x1000, no stall, ack 1 cycle after each stb -> 16 beats addr 0x1000..0x101E, o_biu_data assembled in order, done[0]=1, err[0]=0.
REQ-036 Ch0 and ch1 en same cycle after reset, both held -> ch0 served first, ch1 next, then ch0 again (alternation).
REQ-037 Ch1 write, i_wb_stall=1 for 3 cycles at beat 5 -> addr 0x..0A and o_wb_data=line[95:80] held 4 cycles, 16 beats total.
REQ-038 Read with i_wb_err on response 3 -> stb drops next cycle, waits for outstanding responses, done=1, err=1.
REQ-039 Request addr 0x1013 -> first beat addr 0x1000.
REQ-040 Reset asserted at beat 7 -> cyc/stb 0 next cycle, FSM IDLE, no done pulse.
